// File: rtl/program_loader_pkg.sv
// program_loader_pkg: shared definitions for the byte-stream program loader.
//   - state encoding of the frame parser (3-bit)
//   - default frame start marker
//   - width of the word counter (matches the programmer address width)
package program_loader_pkg;

    localparam int unsigned ST_W      = 3;
    localparam int unsigned LDR_CNT_W = 15;
    localparam logic [7:0]  LDR_SYNC_BYTE = 8'hA5;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_LEN_HI  = 3'd1,
        ST_LEN_LO  = 3'd2,
        ST_DATA_HI = 3'd3,
        ST_DATA_LO = 3'd4,
        ST_WRITE   = 3'd5,
        ST_CHECK   = 3'd6
    } ldr_state_t;

endpackage

// File: rtl/program_loader_timeout.sv
// program_loader_timeout: inter-byte idle watchdog.
//   clk, reset   : clock, synchronous active-high reset
//   i_en         : watchdog armed (frame in progress, not in a write cycle)
//   i_kick       : a byte was transferred this cycle
//   o_expired_c  : combinational; this is the TIMEOUT_CYCLES-th idle cycle in a row
module program_loader_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_en,
    input  logic i_kick,
    output logic o_expired_c
);

    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] r_cnt;

    // Reload on every transfer and while disarmed, so an armed window always
    // starts with a full budget; otherwise count down toward 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_kick || !i_en) begin
            r_cnt <= TO_W'(TIMEOUT_CYCLES);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - TO_W'(1);
        end
    end

    assign o_expired_c = i_en && !i_kick && (r_cnt == TO_W'(1));

endmodule

// File: rtl/program_loader.sv
// program_loader: parses a framed program image (sync, 15-bit word count,
// big-endian 16-bit data words, 8-bit checksum) from a byte stream and writes
// each word downstream with a one-cycle strobe.
//   clk, reset    : clock, synchronous active-high reset
//   rx_data/valid : incoming byte stream; rx_ready (combinational) accepts it
//   program_word  : assembled word, valid while lm is high
//   lm            : one-cycle write/advance strobe per word
//   counter_clear : one-cycle pulse after the sync byte is accepted
//   busy          : frame in progress
//   done / error  : sticky result of the last frame
module program_loader
    import program_loader_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE      = LDR_SYNC_BYTE,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [15:0] program_word,
    output logic        lm,
    output logic        counter_clear,
    output logic        busy,
    output logic        done,
    output logic        error
);

    ldr_state_t             r_state;
    logic [LDR_CNT_W-1:0]   r_count;
    logic [7:0]             r_hi;
    logic [7:0]             r_sum;
    logic [15:0]            r_word;
    logic                   r_lm;
    logic                   r_cc;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_error;

    ldr_state_t             w_state_nxt;
    logic [LDR_CNT_W-1:0]   w_count_nxt;
    logic [7:0]             w_hi_nxt;
    logic [7:0]             w_sum_nxt;
    logic [15:0]            w_word_nxt;
    logic                   w_lm_nxt;
    logic                   w_cc_nxt;
    logic                   w_busy_nxt;
    logic                   w_done_nxt;
    logic                   w_error_nxt;

    logic                   w_xfer;
    logic                   w_to_en;
    logic                   w_expired;
    logic [LDR_CNT_W-1:0]   w_len;
    logic [7:0]             w_sum_add;

    // Only the write cycle refuses input; it holds the stream while lm fires.
    assign rx_ready  = (r_state != ST_WRITE);
    assign w_xfer    = rx_valid && rx_ready;
    assign w_to_en   = (r_state != ST_IDLE) && (r_state != ST_WRITE);
    assign w_len     = {r_count[LDR_CNT_W-1:8], rx_data};
    assign w_sum_add = 8'(r_sum + rx_data);

    program_loader_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk         (clk),
        .reset       (reset),
        .i_en        (w_to_en),
        .i_kick      (w_xfer),
        .o_expired_c (w_expired)
    );

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_hi    <= '0;
            r_sum   <= '0;
            r_word  <= '0;
            r_lm    <= 1'b0;
            r_cc    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_hi    <= w_hi_nxt;
            r_sum   <= w_sum_nxt;
            r_word  <= w_word_nxt;
            r_lm    <= w_lm_nxt;
            r_cc    <= w_cc_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_error <= w_error_nxt;
        end
    end

    // Frame parser: next state and next register values.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_hi_nxt    = r_hi;
        w_sum_nxt   = r_sum;
        w_word_nxt  = r_word;
        w_lm_nxt    = 1'b0;
        w_cc_nxt    = 1'b0;
        w_busy_nxt  = r_busy;
        w_done_nxt  = r_done;
        w_error_nxt = r_error;

        case (r_state)
            ST_IDLE: begin
                if (w_xfer && (rx_data == SYNC_BYTE)) begin
                    w_state_nxt = ST_LEN_HI;
                    w_cc_nxt    = 1'b1;
                    w_done_nxt  = 1'b0;
                    w_error_nxt = 1'b0;
                    w_busy_nxt  = 1'b1;
                    w_sum_nxt   = '0;
                    w_count_nxt = '0;
                end
            end
            ST_LEN_HI: begin
                // Bit 7 of the high length byte is not part of the count.
                if (w_xfer) begin
                    w_count_nxt = {rx_data[6:0], 8'h00};
                    w_state_nxt = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (w_xfer) begin
                    w_count_nxt = w_len;
                    if (w_len == '0) begin
                        w_error_nxt = 1'b1;
                        w_busy_nxt  = 1'b0;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_DATA_HI;
                    end
                end
            end
            ST_DATA_HI: begin
                if (w_xfer) begin
                    w_hi_nxt    = rx_data;
                    w_sum_nxt   = w_sum_add;
                    w_state_nxt = ST_DATA_LO;
                end
            end
            ST_DATA_LO: begin
                // lm and the word register together so they line up in WRITE.
                if (w_xfer) begin
                    w_word_nxt  = {r_hi, rx_data};
                    w_sum_nxt   = w_sum_add;
                    w_lm_nxt    = 1'b1;
                    w_state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                w_count_nxt = r_count - LDR_CNT_W'(1);
                w_state_nxt = (r_count == LDR_CNT_W'(1)) ? ST_CHECK : ST_DATA_HI;
            end
            ST_CHECK: begin
                if (w_xfer) begin
                    w_done_nxt  = (w_sum_add == 8'h00);
                    w_error_nxt = (w_sum_add != 8'h00);
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Stalled stream inside a frame aborts it.
        if (w_expired) begin
            w_error_nxt = 1'b1;
            w_busy_nxt  = 1'b0;
            w_state_nxt = ST_IDLE;
        end
    end

    assign program_word  = r_word;
    assign lm            = r_lm;
    assign counter_clear = r_cc;
    assign busy          = r_busy;
    assign done          = r_done;
    assign error         = r_error;

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed bench for program_loader with a word scoreboard.
module tb_program_loader;

    localparam int unsigned TO_CYC = 16;

    logic        clk;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [15:0] program_word;
    logic        lm;
    logic        counter_clear;
    logic        busy;
    logic        done;
    logic        error;

    int n_pass;
    int n_fail;
    int lm_cnt;
    int cc_cnt;
    int cyc;
    logic [15:0] exp_q [$];
    int          lm_t  [$];
    logic [15:0] fw    [4];

    program_loader #(
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (TO_CYC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .program_word  (program_word),
        .lm            (lm),
        .counter_clear (counter_clear),
        .busy          (busy),
        .done          (done),
        .error         (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: scoreboard pop on each lm, handshake sanity every cycle.
    always @(negedge clk) begin
        if (!reset) begin
            chk("rx_ready_vs_lm", 32'(rx_ready), 32'(!lm));
            if (lm) begin
                lm_cnt++;
                lm_t.push_back(cyc);
                chk("lm_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) chk("program_word", 32'(program_word), 32'(exp_q.pop_front()));
            end
            if (counter_clear) cc_cnt++;
        end
    end

    // Present a byte at a falling edge and hold it until accepted.
    task automatic send_byte(input logic [7:0] b);
        int g;
        g = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk("ready_wait", 32'(rx_ready), 32'd1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] lh, input logic [7:0] ll, input int n, input logic bad_cs);
        logic [7:0] sum;
        sum = 8'h00;
        send_byte(8'hA5);
        send_byte(lh);
        send_byte(ll);
        for (int i = 0; i < n; i++) begin
            send_byte(fw[i][15:8]);
            sum = 8'(sum + fw[i][15:8]);
            exp_q.push_back(fw[i]);
            send_byte(fw[i][7:0]);
            sum = 8'(sum + fw[i][7:0]);
        end
        send_byte(8'(8'h00 - sum + (bad_cs ? 8'h01 : 8'h00)));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_rx_ready", 32'(rx_ready), 32'd1);
        chk("rst_word", 32'(program_word), 32'h0);
        chk("rst_lm", 32'(lm), 32'd0);
        chk("rst_cc", 32'(counter_clear), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Junk before sync is discarded.
        send_byte(8'h00);
        send_byte(8'hFF);
        chk("junk_cc", 32'(cc_cnt), 32'd0);
        chk("junk_busy", 32'(busy), 32'd0);

        // Good two-word frame.
        fw[0] = 16'h1234; fw[1] = 16'hABCD;
        lm_cnt = 0; cc_cnt = 0;
        send_frame(8'h00, 8'h02, 2, 1'b0);
        chk("good_done", 32'(done), 32'd1);
        chk("good_error", 32'(error), 32'd0);
        chk("good_busy", 32'(busy), 32'd0);
        chk("good_lm_cnt", 32'(lm_cnt), 32'd2);
        chk("good_cc_cnt", 32'(cc_cnt), 32'd1);

        // Same frame, wrong checksum.
        lm_cnt = 0;
        send_frame(8'h00, 8'h02, 2, 1'b1);
        chk("badcs_error", 32'(error), 32'd1);
        chk("badcs_done", 32'(done), 32'd0);
        chk("badcs_busy", 32'(busy), 32'd0);
        chk("badcs_lm_cnt", 32'(lm_cnt), 32'd2);

        // Zero length.
        lm_cnt = 0;
        send_byte(8'hA5);
        chk("zl_busy_mid", 32'(busy), 32'd1);
        chk("zl_error_cleared", 32'(error), 32'd0);
        send_byte(8'h00);
        send_byte(8'h00);
        chk("zl_error", 32'(error), 32'd1);
        chk("zl_busy", 32'(busy), 32'd0);
        chk("zl_lm_cnt", 32'(lm_cnt), 32'd0);

        // Bit 7 of length high byte ignored: 0x80 0x01 is one word.
        fw[0] = 16'hDEAD;
        lm_cnt = 0;
        send_frame(8'h80, 8'h01, 1, 1'b0);
        chk("len7_done", 32'(done), 32'd1);
        chk("len7_lm_cnt", 32'(lm_cnt), 32'd1);

        // Back-to-back stream with sync bytes inside data.
        fw[0] = 16'hA55A; fw[1] = 16'h0001; fw[2] = 16'hFFA5;
        lm_cnt = 0;
        lm_t.delete();
        send_frame(8'h00, 8'h03, 3, 1'b0);
        chk("b2b_done", 32'(done), 32'd1);
        chk("b2b_error", 32'(error), 32'd0);
        chk("b2b_lm_cnt", 32'(lm_cnt), 32'd3);
        if (lm_t.size() == 3) begin
            chk("b2b_gap0", 32'(lm_t[1] - lm_t[0]), 32'd3);
            chk("b2b_gap1", 32'(lm_t[2] - lm_t[1]), 32'd3);
        end else begin
            chk("b2b_lm_stamps", 32'(lm_t.size()), 32'd3);
        end

        // Stall after the first data byte.
        lm_cnt = 0;
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h12);
        repeat (TO_CYC - 1) @(negedge clk);
        chk("to_error_early", 32'(error), 32'd0);
        chk("to_busy_early", 32'(busy), 32'd1);
        @(negedge clk);
        chk("to_error", 32'(error), 32'd1);
        chk("to_busy", 32'(busy), 32'd0);
        chk("to_lm_cnt", 32'(lm_cnt), 32'd0);

        // Parser is back in IDLE: a fresh frame works.
        fw[0] = 16'h0F0F;
        lm_cnt = 0;
        send_frame(8'h00, 8'h01, 1, 1'b0);
        chk("post_to_done", 32'(done), 32'd1);
        chk("post_to_lm_cnt", 32'(lm_cnt), 32'd1);

        // Reset while waiting for a low data byte.
        lm_cnt = 0;
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h77);
        reset = 1'b1;
        @(negedge clk);
        chk("mrst_rx_ready", 32'(rx_ready), 32'd1);
        chk("mrst_word", 32'(program_word), 32'h0);
        chk("mrst_lm", 32'(lm), 32'd0);
        chk("mrst_cc", 32'(counter_clear), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        chk("mrst_error", 32'(error), 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("mrst_lm_cnt", 32'(lm_cnt), 32'd0);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end

endmodule
